// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access types, FSM states
// and the funct3/direction legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane selection for one data word: formats load data (sign/zero extension)
// and produces the store byte-enable for the same address/size.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = word >> {lane, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        byte_en   = 4'b1111;
        case (funct3)
            F3_B: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
                byte_en   = 4'b0001 << lane;
            end
            F3_BU: begin
                load_data = {24'h0, byte_sel};
                byte_en   = 4'b0001 << lane;
            end
            F3_H: begin
                load_data = {{16{half_sel[15]}}, half_sel};
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            end
            F3_HU: begin
                load_data = {16'h0, half_sel};
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                load_data = word;
                byte_en   = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Load/store stage with wait-stated data memory and core stall.
module lsu_data_memory
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        fault
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    lsu_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [2:0]    f3_reg;
    logic          store_reg;
    logic [31:0]   rdata_reg;
    logic          done_reg;

    logic          req;
    logic          misaligned;
    logic          out_of_range;
    logic          bad;
    logic          accept;
    logic          access;
    logic          in_idle;

    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [2:0]    sel_f3;
    logic          sel_store;
    logic [AW-1:0] idx;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   store_data;

    assign in_idle = (state_reg == IDLE);
    assign req     = mem_read | mem_write;

    assign misaligned   = ((funct3 == F3_W) && (addr[1:0] != 2'b00)) ||
                          (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]);
    // Full upper address compared so out-of-range addresses never alias.
    assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    assign bad          = misaligned || out_of_range || !f3_legal(funct3, mem_write);

    assign accept = in_idle && req && !bad;
    assign fault  = !reset && in_idle && req && bad;
    assign stall  = !reset && (accept || (state_reg == WAIT));
    assign done   = done_reg;
    assign rdata  = rdata_reg;

    // Zero-wait accesses happen on the acceptance edge, so use live inputs.
    assign sel_addr  = in_idle ? addr[AW+1:0] : addr_reg;
    assign sel_wdata = in_idle ? wdata        : wdata_reg;
    assign sel_f3    = in_idle ? funct3       : f3_reg;
    assign sel_store = in_idle ? mem_write    : store_reg;
    assign idx       = sel_addr[AW+1:2];

    assign access = !reset &&
                    ((accept && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == '0)));

    lsu_load_align u_align (
        .word      (mem[idx]),
        .lane      (sel_addr[1:0]),
        .funct3    (sel_f3),
        .load_data (load_data),
        .byte_en   (byte_en)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_data[gi*8 +: 8] =
            (sel_f3 == F3_W) ? sel_wdata[gi*8 +: 8] :
            (sel_f3 == F3_H) ? sel_wdata[(gi%2)*8 +: 8] :
                               sel_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (access && sel_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][i*8 +: 8] <= store_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            f3_reg    <= '0;
            store_reg <= 1'b0;
            rdata_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= addr[AW+1:0];
                        wdata_reg <= wdata;
                        f3_reg    <= funct3;
                        store_reg <= mem_write;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= RESP;
                            done_reg  <= 1'b1;
                            if (!mem_write) rdata_reg <= load_data;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        done_reg  <= 1'b1;
                        if (!store_reg) rdata_reg <= load_data;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Scoreboard bench for lsu_data_memory: a 2-wait-state and a zero-wait instance
// share one set of stimulus registers, steered by sel.
module tb_lsu_data_memory;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        mr = 1'b0;
    logic        mw = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;

    logic [31:0] rdata_a, rdata_b, rdata_s;
    logic        done_a, done_b, done_s;
    logic        stall_a, stall_b, stall_s;
    logic        fault_a, fault_b, fault_s;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    lsu_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .mem_read(mr & ~sel), .mem_write(mw & ~sel),
        .funct3(f3), .addr(a), .wdata(wd),
        .rdata(rdata_a), .done(done_a), .stall(stall_a), .fault(fault_a)
    );

    lsu_data_memory #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .mem_read(mr & sel), .mem_write(mw & sel),
        .funct3(f3), .addr(a), .wdata(wd),
        .rdata(rdata_b), .done(done_b), .stall(stall_b), .fault(fault_b)
    );

    assign rdata_s = sel ? rdata_b : rdata_a;
    assign done_s  = sel ? done_b  : done_a;
    assign stall_s = sel ? stall_b : stall_a;
    assign fault_s = sel ? fault_b : fault_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One accepted access: drive at negedge, sample 1ns later each cycle.
    task automatic do_op(input string tag, input logic s, input logic wr,
                         input logic [2:0] fn, input logic [31:0] ad, input logic [31:0] dat,
                         input int exp_stall, input logic [31:0] exp_data);
        int cyc = 0;
        int stalls = 0;
        @(negedge clk);
        sel = s; mr = ~wr; mw = wr; f3 = fn; a = ad; wd = dat;
        if (!wr) exp_q.push_back(exp_data);
        #1;
        check({tag, "_fault"}, 32'(fault_s), 32'd0);
        while (!done_s && cyc < 20) begin
            if (stall_s) stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        mr = 1'b0; mw = 1'b0;
        check({tag, "_done"}, 32'(done_s), 32'd1);
        check({tag, "_stallcnt"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_latency"}, 32'(cyc), 32'(exp_stall));
        check({tag, "_respstall"}, 32'(stall_s), 32'd0);
        if (!wr) check({tag, "_rdata"}, rdata_s, exp_q.pop_front());
        $display("op %s addr=%h wdata=%h rdata=%h stalls=%0d", tag, ad, dat, rdata_s, stalls);
    endtask

    task automatic do_fault(input string tag, input logic wr, input logic [2:0] fn,
                            input logic [31:0] ad);
        @(negedge clk);
        sel = 1'b0; mr = ~wr; mw = wr; f3 = fn; a = ad; wd = 32'h5555_5555;
        #1;
        check({tag, "_fault"}, 32'(fault_s), 32'd1);
        check({tag, "_stall"}, 32'(stall_s), 32'd0);
        check({tag, "_done"}, 32'(done_s), 32'd0);
        @(negedge clk);
        mr = 1'b0; mw = 1'b0;
        #1;
        check({tag, "_nostall"}, 32'(stall_s), 32'd0);
        check({tag, "_nodone"}, 32'(done_s), 32'd0);
        $display("fault %s addr=%h f3=%b", tag, ad, fn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_stall_a", 32'(stall_a), 32'd0);
        check("rst_fault_a", 32'(fault_a), 32'd0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("sw10",   0, 1, F3_W,  32'h10, 32'hDEAD_BEEF, 3, 32'h0);
        do_op("lw10",   0, 0, F3_W,  32'h10, 32'h0, 3, 32'hDEAD_BEEF);
        do_op("lh12",   0, 0, F3_H,  32'h12, 32'h0, 3, 32'hFFFF_DEAD);
        do_op("lhu12",  0, 0, F3_HU, 32'h12, 32'h0, 3, 32'h0000_DEAD);
        do_op("lb10",   0, 0, F3_B,  32'h10, 32'h0, 3, 32'hFFFF_FFEF);
        do_op("lbu11",  0, 0, F3_BU, 32'h11, 32'h0, 3, 32'h0000_00BE);
        do_op("sb13",   0, 1, F3_B,  32'h13, 32'h0000_00A5, 3, 32'h0);
        do_op("lw10b",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_BEEF);
        do_op("sh10",   0, 1, F3_H,  32'h10, 32'h0000_1234, 3, 32'h0);
        do_op("lw10c",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        do_op("lh10",   0, 0, F3_H,  32'h10, 32'h0, 3, 32'h0000_1234);
        do_op("lb12",   0, 0, F3_B,  32'h12, 32'h0, 3, 32'hFFFF_FFAD);

        do_fault("lw11",  0, F3_W,   32'h11);
        do_op("rd_f1",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        do_fault("sh13",  1, F3_H,   32'h13);
        do_op("rd_f2",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        do_fault("sw400", 1, F3_W,   32'h400);
        do_op("rd_f3",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        do_fault("f3_011", 0, 3'b011, 32'h10);
        do_op("rd_f4",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        do_fault("sbu",   1, F3_BU,  32'h10);
        do_op("rd_f5",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);

        // Reset in the last wait cycle must discard the pending store.
        do_op("sw20z",  0, 1, F3_W,  32'h20, 32'h0, 3, 32'h0);
        do_op("lw10d",  0, 0, F3_W,  32'h10, 32'h0, 3, 32'hA5AD_1234);
        @(negedge clk);
        sel = 1'b0; mr = 1'b0; mw = 1'b1; f3 = F3_W; a = 32'h20; wd = 32'h1234_5678;
        #1;
        check("rstop_accept", 32'(stall_a), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstop_wait", 32'(stall_a), 32'd1);
        reset = 1'b1; mw = 1'b0;
        #1;
        check("rstop_stall", 32'(stall_a), 32'd0);
        check("rstop_done", 32'(done_a), 32'd0);
        check("rstop_rdata", rdata_a, 32'h0);
        $display("reset mid-store addr=20 stall=%b rdata=%h", stall_a, rdata_a);
        @(negedge clk);
        reset = 1'b0;
        do_op("lw20",   0, 0, F3_W,  32'h20, 32'h0, 3, 32'h0);

        do_op("w0_sw04", 1, 1, F3_W, 32'h04, 32'hCAFE_F00D, 1, 32'h0);
        do_op("w0_lw04", 1, 0, F3_W, 32'h04, 32'h0, 1, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Load/store stage directly downstream of the ALU.
- Takes the ALU result as the effective address, register read-data-2 as store data, and control-unit MemRead/MemWrite plus funct3 as access type.
- Owns the data memory array with a configurable number of wait states; stalls the core while an access is in flight.
- Returns aligned, sign- or zero-extended load data for the register-file write-back mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data array (byte address range 0 .. 4*DEPTH_WORDS-1).
- WAIT_CYCLES, 1, extra cycles between request acceptance and the memory access (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request (control unit MemRead).
- mem_write  in  1  store request (control unit MemWrite); wins if both are high.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- addr  in  32  byte address (ALU Result).
- wdata  in  32  store data, low bits used for B/H.
- rdata  out  32  formatted load data, valid when done=1, held until the next done.
- done  out  1  one-cycle pulse: access completed.
- stall  out  1  core must hold PC/pipeline while high.
- fault  out  1  one-cycle pulse: request rejected, no access performed.

Behaviour:
- Reset clk, reset: clk and reset as already decided (reset asynchronous, active-high).
- Reset values: state IDLE, rdata=0, done=0, fault=0, stall=0, wait counter=0. Memory array is not cleared.
- States:
  - IDLE: req = mem_read|mem_write.
  - WAIT: counts down the wait states.
  - RESP: done=1, stall=0.
- Request validity, checked in IDLE, combinational:
  - Fault if any of: W with addr[1:0]≠0; H/HU with addr[0]≠0; addr[31:2] ≥ DEPTH_WORDS; funct3 not legal for the direction (011, 110, 111 always; 100/101 on a store).
- Fault path:
  - fault=1, stall=0, done=0 in the same cycle.
  - State stays IDLE; memory untouched.
- Accept path:
  - Latch addr, wdata, funct3 and direction; stall=1 in the acceptance cycle.
  - If WAIT_CYCLES=0, go straight to RESP, performing the access on that edge.
  - Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - stall=1.
  - When counter=0: perform the access on this edge and go to RESP; otherwise decrement.
- Access:
  - Stores write only the addressed byte lanes, little-endian. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}.
  - Loads register the formatted word into rdata: byte/half extracted by lane, sign-extended for B/H, zero-extended for BU/HU.
- RESP:
  - done=1, stall=0.
  - Unconditionally returns to IDLE; the core advances on this edge, so the same instruction is never re-accepted.
  - A new request is evaluated only in IDLE.
- Latency: request seen in cycle T → stall high in cycles T..T+WAIT_CYCLES → done in cycle T+WAIT_CYCLES+1.
- Store-then-load to the same word on consecutive instructions returns the new data, since accesses are serialised.
- Inputs are ignored outside IDLE.
- Reset mid-operation: return to IDLE immediately. A store not yet performed is discarded; rdata is cleared to 0.
- Address bits above the range are checked as part of the range test, never silently wrapped.

Optional Feature:
- LSU_MEM_INIT_EN
  - Defined: memory array preloaded at elaboration from "data.mem" (hex, one word per line).
  - Undefined: contents are X until written; no file access.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (IDLE, WAIT, RESP).
- Sub-module lsu_load_align: combinational.
  - Inputs: 32-bit word, addr[1:0], funct3.
  - Outputs: formatted load data and the 4-bit store byte-enable for the same lane select.

Test Plan (WAIT_CYCLES=2 unless stated):
- SW 0x10 ← 0xDEADBEEF, then LW 0x10: each op has stall high 3 cycles and done in cycle 4; LW rdata=0xDEADBEEF.
- After the above: LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD; LB 0x10 → 0xFFFFFFEF; LBU 0x11 → 0x000000BE.
- SB 0x13 ← 0x000000A5, then LW 0x10 → 0xA5ADBEEF; SH 0x10 ← 0x00001234, then LW 0x10 → 0xA5AD1234.
- Faults, each giving fault=1 same cycle, stall=0, no done, and word 0x10 unchanged on re-read:
  - LW 0x11
  - SH 0x13
  - SW 0x400 (DEPTH_WORDS=256)
  - funct3=011
  - store with funct3=100
- Reset asserted in the WAIT cycle of SW 0x20 ← 0x12345678 (word previously 0x0): stall/done/rdata go 0 immediately; a later LW 0x20 → 0x00000000.
- WAIT_CYCLES=0 build, back-to-back SW 0x04 ← 0xCAFEF00D then LW 0x04: each has stall high 1 cycle and done the next cycle; LW rdata=0xCAFEF00D.
